// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined adder/subtractor with group
// carry-lookahead and optional signed saturation.
//
// Stage 1 forms the effective addend, the bit-level generate/propagate
// terms, and the per-group generate/propagate terms. Stage 2 resolves the
// group carries by lookahead, completes the sum, and applies saturation.
// Stage 2 also produces the flags.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  operand handshake (A, B, op, cin)
//   A, B            WIDTH-bit two's complement operands
//   op              00 ADD, 01 SUB, 10 ADC, 11 SBB
//   cin             carry input for ADC/SBB
//   out_valid/ready result handshake
//   S               result (saturated when SAT=1 and overflow)
//   cout, ovf       carry out / signed overflow of the unsaturated sum
//   zero, neg       S == 0, S[WIDTH-1]
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NG = WIDTH / GROUP;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // ---------------- stage 1: operand decode and group G/P ----------------
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;

  always_comb begin : s1_decode
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value unassigned (no latch).
    w_b_eff = B;
    w_c0    = 1'b0;
    case (op_e'(op))
      OP_ADD: ;
      OP_SUB: begin w_b_eff = ~B; w_c0 = 1'b1; end
      OP_ADC: w_c0 = cin;
      OP_SBB: begin w_b_eff = ~B; w_c0 = cin; end
      default: ;
    endcase
  end

  assign w_p = A ^ w_b_eff;
  assign w_g = A & w_b_eff;

  // Group generate/propagate: a group generates if some bit generates and
  // every bit above it inside the group propagates.
  always_comb begin : s1_group_gp
    logic v_g;
    logic v_p;
    w_gg = '0;
    w_gp = '0;
    for (int k = 0; k < NG; k++) begin
      v_g = 1'b0;
      v_p = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        v_g = w_g[k*GROUP+i] | (w_p[k*GROUP+i] & v_g);
        v_p = v_p & w_p[k*GROUP+i];
      end
      w_gg[k] = v_g;
      w_gp[k] = v_p;
    end
  end

  // Stage 1 registers. The carry-in and addend MSBs carry the decoded
  // operation forward; the bit-level terms are needed to finish the sum.
  logic             r_v1;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_g;
  logic [NG-1:0]    r_gg;
  logic [NG-1:0]    r_gp;
  logic             r_c0;
  logic             r_a_msb;
  logic             r_b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      // NOTE: datapath registers are plain flops, not a memory array, so
      // resetting them is cheap and keeps outputs deterministic.
      r_v1    <= 1'b0;
      r_p     <= '0;
      r_g     <= '0;
      r_gg    <= '0;
      r_gp    <= '0;
      r_c0    <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else if (in_ready) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_p     <= w_p;
        r_g     <= w_g;
        r_gg    <= w_gg;
        r_gp    <= w_gp;
        r_c0    <= w_c0;
        r_a_msb <= A[WIDTH-1];
        r_b_msb <= w_b_eff[WIDTH-1];
      end
    end
  end

  // ---------------- stage 2: lookahead, sum, saturation ----------------
  logic [NG:0]      w_src;
  logic [NG:0]      w_gc;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_s;

  // Source of a carry entering the group chain: index 0 is the carry-in,
  // index j>0 is group j-1 generating.
  assign w_src = {r_gg, r_c0};

  // Flattened lookahead: carry into group k is the OR over every source j
  // of that source ANDed with the propagates of groups j..k-1.
  always_comb begin : s2_lookahead
    logic v_c;
    logic v_term;
    w_gc    = '0;
    w_gc[0] = r_c0;
    for (int k = 1; k <= NG; k++) begin
      v_c = 1'b0;
      for (int j = 0; j <= k; j++) begin
        v_term = w_src[j];
        for (int m = j; m < k; m++) v_term = v_term & r_gp[m];
        v_c = v_c | v_term;
      end
      w_gc[k] = v_c;
    end
  end

  // Inside each group the carry ripples at most GROUP bits from the
  // lookahead carry entering that group.
  always_comb begin : s2_sum
    logic v_c;
    w_sum = '0;
    for (int k = 0; k < NG; k++) begin
      v_c = w_gc[k];
      for (int i = 0; i < GROUP; i++) begin
        w_sum[k*GROUP+i] = r_p[k*GROUP+i] ^ v_c;
        v_c = r_g[k*GROUP+i] | (r_p[k*GROUP+i] & v_c);
      end
    end
  end

  assign w_ovf = (r_a_msb == r_b_msb) && (w_sum[WIDTH-1] != r_a_msb);

  // Saturate toward the sign shared by both addends.
  assign w_s = ((SAT != 0) && w_ovf)
             ? (r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
             : w_sum;

  logic             r_v2;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
      r_neg  <= 1'b0;
    end else if (in_ready) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s    <= w_s;
        r_cout <= w_gc[NG];
        r_ovf  <= w_ovf;
        r_zero <= (w_s == '0);
        r_neg  <= w_s[WIDTH-1];
      end
    end
  end

  // Whole pipe advances unless a valid result is waiting on the consumer.
  assign in_ready  = ~(r_v2 & ~out_ready);
  assign out_valid = r_v2;
  assign S         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Testbench for cla_addsub_pipe: two instances (SAT=0 and SAT=1) share the
// same stimulus; a scoreboard queue of accepted operations is checked
// against a plain-arithmetic model whenever a result transfers.
module tb_cla_addsub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         cin = 1'b0;
  logic         out_ready = 1'b1;

  logic         in_ready0, out_valid0, cout0, ovf0, zero0, neg0;
  logic [W-1:0] s0;
  logic         in_ready1, out_valid1, cout1, ovf1, zero1, neg1;
  logic [W-1:0] s1;

  cla_addsub_pipe #(.WIDTH(W), .GROUP(4), .SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .A(a), .B(b), .op(op), .cin(cin), .out_valid(out_valid0),
    .out_ready(out_ready), .S(s0), .cout(cout0), .ovf(ovf0), .zero(zero0),
    .neg(neg0)
  );

  cla_addsub_pipe #(.WIDTH(W), .GROUP(4), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .A(a), .B(b), .op(op), .cin(cin), .out_valid(out_valid1),
    .out_ready(out_ready), .S(s1), .cout(cout1), .ovf(ovf1), .zero(zero1),
    .neg(neg1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } txn_t;

  txn_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference: {S, cout, ovf, zero, neg} from ordinary (W+1)-bit addition.
  function automatic logic [W+3:0] model(input txn_t t, input bit sat);
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   raw;
    logic         v;
    logic [W-1:0] s;
    bb  = t.op[0] ? ~t.b : t.b;
    c0  = t.op[1] ? t.cin : t.op[0];
    raw = {1'b0, t.a} + {1'b0, bb} + {{W{1'b0}}, c0};
    v   = (t.a[W-1] == bb[W-1]) && (raw[W-1] != t.a[W-1]);
    s   = raw[W-1:0];
    if (sat && v) s = t.a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return {s, raw[W], v, (s == '0), s[W-1]};
  endfunction

  // Scoreboard monitor: sampled on the falling edge, the transfer happens
  // on the following rising edge.
  txn_t         m_t;
  logic [W+3:0] m_e0, m_e1;
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_output S=%h with nothing outstanding", s0);
      end else begin
        m_t  = q.pop_front();
        m_e0 = model(m_t, 1'b0);
        m_e1 = model(m_t, 1'b1);
        n_cmp++;
        if ({s0, cout0, ovf0, zero0, neg0} !== m_e0) begin
          n_err++;
          $display("FAIL result_sat0 op=%0d a=%h b=%h cin=%0d got=%h required=%h",
                   m_t.op, m_t.a, m_t.b, m_t.cin, {s0, cout0, ovf0, zero0, neg0}, m_e0);
        end
        n_cmp++;
        if ({out_valid1, s1, cout1, ovf1, zero1, neg1} !== {1'b1, m_e1}) begin
          n_err++;
          $display("FAIL result_sat1 op=%0d a=%h b=%h cin=%0d got=%h required=%h",
                   m_t.op, m_t.a, m_t.b, m_t.cin,
                   {out_valid1, s1, cout1, ovf1, zero1, neg1}, {1'b1, m_e1});
        end
      end
    end
  end

  // Drive one operand set and hold it until accepted (bounded).
  task automatic send(input logic [1:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic c);
    int waited;
    bit ok;
    waited = 0; ok = 1'b0;
    op = o; a = x; b = y; cin = c; in_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      if (in_ready0) ok = 1'b1;
      else begin
        waited++;
        if (waited > 50) begin
          n_cmp++; n_err++;
          $display("FAIL send_timeout in_ready got 0 required 1");
          break;
        end
      end
    end
    if (ok) q.push_back(txn_t'{o, x, y, c});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k;
    in_valid = 1'b0;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout outstanding got %0d required 0", q.size());
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    // Operands offered during reset must never produce a result.
    in_valid = 1'b1; a = 16'h1234; b = 16'h0001; op = 2'b00;
    #2;
    n_cmp++;
    if ({out_valid0, in_ready0, s0, cout0, ovf0, zero0, neg0} !==
        {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state_sat0 got %h required %h",
               {out_valid0, in_ready0, s0, cout0, ovf0, zero0, neg0},
               {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid1, in_ready1, s1, zero1} !== {1'b0, 1'b1, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL reset_hold_sat1 got %h required %h",
               {out_valid1, in_ready1, s1, zero1}, {1'b0, 1'b1, 16'h0000, 1'b1});
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset got %b required 1", in_ready0);
    end
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    // ADD 0x7FFF + 0x0001: literal expectations and two-edge latency.
    send(2'b00, 16'h7FFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early out_valid got %b required 0", out_valid0);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid0, s0, cout0, ovf0, zero0, neg0} !==
        {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL add_ovf_sat0 got %h required %h",
               {out_valid0, s0, cout0, ovf0, zero0, neg0},
               {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    end
    n_cmp++;
    if ({s1, ovf1, neg1} !== {16'h7FFF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL add_ovf_sat1 got %h required %h", {s1, ovf1, neg1},
               {16'h7FFF, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    // Boundary cases, issued back to back; checked by the scoreboard.
    send(2'b01, 16'h8000, 16'h0001, 1'b0);  // SUB negative overflow
    send(2'b01, 16'h0005, 16'h0005, 1'b0);  // SUB to zero, cout=1
    send(2'b11, 16'h0005, 16'h0005, 1'b0);  // SBB borrow -> 0xFFFF
    send(2'b10, 16'hFFFF, 16'h0000, 1'b1);  // ADC carry through all groups
    send(2'b00, 16'h1234, 16'h1111, 1'b1);  // ADD ignores cin
    send(2'b01, 16'h0003, 16'h0007, 1'b0);  // SUB ignores cin
    send(2'b10, 16'h7FFF, 16'h0000, 1'b1);  // ADC positive overflow
    send(2'b11, 16'h8000, 16'h0000, 1'b0);  // SBB negative overflow
    send(2'b00, 16'h0F0F, 16'h00F1, 1'b0);  // carry between groups
    drain();
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] e;
    int           k;
    out_ready = 1'b1;
    fork
      begin
        send(2'b00, 16'h0101, 16'h0202, 1'b0);
        send(2'b01, 16'h1000, 16'h0001, 1'b0);
        send(2'b10, 16'h00FF, 16'h0001, 1'b1);
        send(2'b11, 16'h4000, 16'h4000, 1'b1);
        in_valid = 1'b0;
      end
      begin
        k = 0;
        while (!out_valid0 && k < 20) begin
          @(posedge clk); #1;
          k++;
        end
        if (!out_valid0) begin
          n_cmp++; n_err++;
          $display("FAIL b2b_no_output out_valid got 0 required 1");
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          n_cmp++;
          if ({in_ready0, in_ready1, out_valid0} !== 3'b001) begin
            n_err++;
            $display("FAIL stall_handshake got %b required 001",
                     {in_ready0, in_ready1, out_valid0});
          end
          n_cmp++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL stall_hold nothing outstanding required 1 entry");
          end else begin
            e = model(q[0], 1'b0);
            if (s0 !== e[W+3:4]) begin
              n_err++;
              $display("FAIL stall_hold S got %h required %h", s0, e[W+3:4]);
            end
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_random_flow();
    bit done;
    logic [W-1:0] x, y;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          case ($urandom_range(0, 4))
            0: x = 16'hFFFF;
            1: x = 16'h8000;
            2: x = 16'h7FFF;
            default: x = W'($urandom);
          endcase
          y = ($urandom_range(0, 3) == 0) ? 16'h0001 : W'($urandom);
          send(2'($urandom_range(0, 3)), x, y, 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    send(2'b00, 16'h1111, 16'h2222, 1'b0);
    send(2'b01, 16'h3333, 16'h1111, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid0, out_valid1, in_ready0, s0, zero0} !==
        {1'b0, 1'b0, 1'b1, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL reset_midflight got %h required %h",
               {out_valid0, out_valid1, in_ready0, s0, zero0},
               {1'b0, 1'b0, 1'b1, 16'h0000, 1'b1});
    end
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
        n_err++;
        $display("FAIL stale_after_reset out_valid got %b%b required 00",
                 out_valid0, out_valid1);
      end
    end
    @(posedge clk); #1;
    send(2'b10, 16'h00FF, 16'h0F00, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_latency_early got %b required 0", out_valid0);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid0 !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_latency got %b required 1", out_valid0);
    end
    @(posedge clk); #1;
    drain();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random_flow();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
